load_store_unit: RTL
====================

# load_store_unit

Initiator side of the core's data-memory interface. Accepts one load or store per handshake from the execute stage and generates the word-aligned address, byte-lane enables and lane-replicated store data for a word-organised data memory. It waits for the memory acknowledge with a bounded timeout, then returns load data extracted and sign/zero-extended per Funct3. It sits between the core datapath and the data memory responder.

## Interface
- ADDRESS_WIDTH, 9, byte address width; bits [1:0] are the byte offset within a word.
- DATA_WIDTH, 32, data width; fixed at 32, with 4 byte lanes.
- TIMEOUT, 15, maximum cycles MemReq may stay high without MemAck before the access is abandoned; must be 1 or more.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- ReqValid  in  1  core presents an access.
- ReqReady  out  1  unit is idle and accepts ReqValid this cycle.
- MemRead  in  1  access is a load.
- MemWrite  in  1  access is a store.
- Funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Address  in  ADDRESS_WIDTH  byte address.
- WriteData  in  32  store data; the relevant bits are the low byte, low halfword or the whole word.
- RespValid  out  1  one-cycle pulse that completes the accepted access.
- ReadData  out  32  extended load data; valid with RespValid; 0 for stores and errors.
- Misaligned  out  1  valid with RespValid; the access was not issued.
- Timeout  out  1  valid with RespValid; the memory did not acknowledge.
- MemReq  out  1  request to memory; held high until MemAck or timeout.
- MemAck  in  1  memory completes the request in this cycle.
- MemAddr  out  ADDRESS_WIDTH  {Address[ADDRESS_WIDTH-1:2], 2'b00}.
- MemWe  out  1  1 for a store, 0 for a load.
- MemByteEn  out  4  lane enables for stores; 4'b0000 for loads.
- MemWData  out  32  lane-replicated store data.
- MemRData  in  32  word read from memory; sampled in the MemAck cycle.

## Operation
- The state machine has four states: IDLE, REQ, RESP and ERR.
- IDLE:
  - ReqReady=1.
  - On ReqValid with MemRead or MemWrite set, the unit latches Address, Funct3, WriteData and the direction. MemRead takes priority if both are set.
  - ReqValid with neither MemRead nor MemWrite set is ignored.
- Alignment check, done at acceptance:
  - H/HU requires Address[0]=0.
  - W requires Address[1:0]=00.
  - B/BU is always aligned.
  - A misaligned access goes to ERR with Misaligned=1 and never asserts MemReq.
  - Funct3 values 011, 110 and 111 are treated as W.
- Aligned accesses go to REQ:
  - MemReq=1 and the cycle counter is cleared.
  - When MemAck=1, load data is captured and the state moves to RESP.
  - Otherwise the counter increments. When MemReq has been high for TIMEOUT cycles without MemAck, the state moves to ERR with Timeout=1.
- RESP and ERR each drive RespValid=1 for exactly one cycle, then return to IDLE.
- Store lanes, where off = Address[1:0]:
  - SB: MemByteEn = 4'b0001 << off; MemWData = {4{WriteData[7:0]}}.
  - SH: MemByteEn = 0011 (off=0) or 1100 (off=2); MemWData = {2{WriteData[15:0]}}.
  - SW: MemByteEn = 1111; MemWData = WriteData.
- Load extraction:
  - The source is w = MemRData >> (8*off).
  - LB/LBU: w[7:0], sign- or zero-extended.
  - LH/LHU: w[15:0], sign- or zero-extended.
  - LW: the whole word.
- Memory-side outputs are registered and stable for the whole time MemReq is high. MemAck is ignored whenever MemReq=0.
- ReqValid while busy is ignored because ReqReady=0; the core holds its request until ReqReady.

## Timing
- Reset (first edge with rst_n=0):
  - State goes to IDLE and the counter clears.
  - Every output is 0 except ReqReady=1.
- Reset mid-access: the access is abandoned. MemReq and RespValid are 0 after that edge, and no response is ever issued for it.
- Acceptance at edge E0: MemReq is high in cycle 1.
- Fastest acknowledge: MemAck in cycle 1 gives RespValid in cycle 2. A new request is accepted at the end of cycle 3.
- Acknowledge after k wait cycles: RespValid in cycle 2+k.
- Misaligned access: RespValid in cycle 1 and no memory cycle.
- Timeout: MemReq is high for exactly TIMEOUT cycles, then RespValid follows in the next cycle.
- MemAck arriving in the same cycle the counter reaches TIMEOUT counts as an acknowledge, not a timeout.
- ReadData, Misaligned and Timeout are held until the next RespValid. They are cleared only by reset.

## Test plan
- SB, Address=0x0D, WriteData=0x000000A5 -> MemAddr=0x0C, MemByteEn=0010, MemWData=0xA5A5A5A5, MemWe=1; with immediate ack, RespValid arrives 2 cycles after acceptance and ReadData=0.
- LB and LBU at Address=0x0E with MemRData=0x12F03456 -> LB gives ReadData=0xFFFFFFF0; LBU gives 0x000000F0.
- LH at 0x02 with MemRData=0x80017FFF gives ReadData=0xFFFF8001. LH at 0x03 gives Misaligned=1 with RespValid 1 cycle after acceptance and MemReq never high.
- LW at 0x10 with MemAck held low and TIMEOUT=15 -> MemReq is high for exactly 15 cycles, then RespValid=1, Timeout=1, ReadData=0. A MemAck arriving afterwards is ignored.
- Ack after 3 wait cycles with ReqValid held high throughout -> exactly one RespValid, ReqReady=0 during REQ, and the second request is accepted only after IDLE is re-entered.
- rst_n=0 pulsed while in REQ -> MemReq drops at that edge, no RespValid follows, and ReqReady=1 on the next cycle.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side bus bundles
// for the load/store unit.
interface load_store_unit_req_if #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 32
);
  logic                     ReqValid;
  logic                     ReqReady;
  logic                     MemRead;
  logic                     MemWrite;
  logic [2:0]               Funct3;
  logic [ADDRESS_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0]    WriteData;
  logic                     RespValid;
  logic [DATA_WIDTH-1:0]    ReadData;
  logic                     Misaligned;
  logic                     Timeout;

  modport master (
    output ReqValid, MemRead, MemWrite, Funct3, Address, WriteData,
    input  ReqReady, RespValid, ReadData, Misaligned, Timeout
  );

  modport slave (
    input  ReqValid, MemRead, MemWrite, Funct3, Address, WriteData,
    output ReqReady, RespValid, ReadData, Misaligned, Timeout
  );
endinterface

interface load_store_unit_mem_if #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 32
);
  logic                     MemReq;
  logic                     MemAck;
  logic [ADDRESS_WIDTH-1:0] MemAddr;
  logic                     MemWe;
  logic [3:0]               MemByteEn;
  logic [DATA_WIDTH-1:0]    MemWData;
  logic [DATA_WIDTH-1:0]    MemRData;

  modport master (
    output MemReq, MemAddr, MemWe, MemByteEn, MemWData,
    input  MemAck, MemRData
  );

  modport slave (
    input  MemReq, MemAddr, MemWe, MemByteEn, MemWData,
    output MemAck, MemRData
  );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory initiator: aligns, lane-steers and extends
// loads/stores with a bounded wait on the memory acknowledge.
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  load_store_unit_req_if.slave  req,
  load_store_unit_mem_if.master mem
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          we_q;
  logic          ready_q;
  logic          rvalid_q;
  logic          mis_q;
  logic          to_q;
  logic          mreq_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] wdata_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;

  logic          acc_d;
  logic          is_h_d;
  logic          is_w_d;
  logic          mis_d;
  logic          sx_d;
  logic [1:0]    off_d;
  logic [3:0]    be_d;
  logic [DW-1:0] wdata_d;
  logic [DW-1:0] word_d;
  logic [DW-1:0] rdata_d;

  // Request decode: size, lanes and alignment
  always_comb begin
    off_d   = req.Address[1:0];
    acc_d   = req.ReqValid && (req.MemRead || req.MemWrite);
    is_h_d  = 1'b0;
    is_w_d  = 1'b0;
    be_d    = 4'b0000;
    wdata_d = req.WriteData;
    unique case (1'b1)
      req.Funct3[1]: begin
        is_w_d = 1'b1;
        be_d   = 4'b1111;
      end
      !req.Funct3[1] && req.Funct3[0]: begin
        is_h_d  = 1'b1;
        be_d    = off_d[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req.WriteData[15:0]}};
      end
      default: begin
        be_d    = 4'b0001 << off_d;
        wdata_d = {4{req.WriteData[7:0]}};
      end
    endcase
    if (req.MemRead) be_d = 4'b0000;
    mis_d = (is_h_d && off_d[0]) ||
            (is_w_d && (off_d != 2'b00));
  end

  // Load extraction from the acknowledged word
  always_comb begin
    sx_d    = !f3_q[2];
    word_d  = mem.MemRData >> {off_q, 3'b000};
    rdata_d = word_d;
    unique case (1'b1)
      f3_q[1]: rdata_d = word_d;
      !f3_q[1] && f3_q[0]:
        rdata_d = {{(DW-16){sx_d & word_d[15]}},
                   word_d[15:0]};
      default:
        rdata_d = {{(DW-8){sx_d & word_d[7]}},
                   word_d[7:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      off_q    <= '0;
      we_q     <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
      to_q     <= 1'b0;
      mreq_q   <= 1'b0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      be_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc_d) begin
            ready_q <= 1'b0;
            cnt_q   <= '0;
            f3_q    <= req.Funct3;
            off_q   <= off_d;
            we_q    <= !req.MemRead;
            if (mis_d) begin
              state_q  <= ERR;
              rvalid_q <= 1'b1;
              mis_q    <= 1'b1;
              to_q     <= 1'b0;
              rdata_q  <= '0;
            end else begin
              state_q <= REQ;
              mreq_q  <= 1'b1;
              addr_q  <= {req.Address[AW-1:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
            end
          end
        end
        REQ: begin
          // An ack in the final allowed cycle still wins
          if (mem.MemAck) begin
            state_q  <= RESP;
            mreq_q   <= 1'b0;
            rvalid_q <= 1'b1;
            mis_q    <= 1'b0;
            to_q     <= 1'b0;
            rdata_q  <= we_q ? '0 : rdata_d;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q  <= ERR;
            mreq_q   <= 1'b0;
            rvalid_q <= 1'b1;
            mis_q    <= 1'b0;
            to_q     <= 1'b1;
            rdata_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP, ERR: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
          ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req.ReqReady   = ready_q;
  assign req.RespValid  = rvalid_q;
  assign req.ReadData   = rdata_q;
  assign req.Misaligned = mis_q;
  assign req.Timeout    = to_q;
  assign mem.MemReq     = mreq_q;
  assign mem.MemAddr    = addr_q;
  assign mem.MemWe      = we_q & mreq_q;
  assign mem.MemByteEn  = be_q;
  assign mem.MemWData   = wdata_q;
endmodule
